// File: rtl/amo_queue.sv
// In-order multi-entry AMO buffer between LSU and cache, with registered issue FSM,
// speculative-flush pruning and result return. Optional ack watchdog: AMO_QUEUE_TIMEOUT_EN.
module amo_queue #(
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned PLEN           = 56,
  parameter int unsigned XLEN           = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr_i,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [3:0]                     amo_op_i,
  input  logic [PLEN-1:0]                paddr_i,
  input  logic [XLEN-1:0]                data_i,
  input  logic [1:0]                     data_size_i,
  output logic                           amo_req_req_o,
  output logic [3:0]                     amo_req_amo_op_o,
  output logic [1:0]                     amo_req_size_o,
  output logic [63:0]                    amo_req_operand_a_o,
  output logic [63:0]                    amo_req_operand_b_o,
  input  logic                           amo_resp_ack_i,
  input  logic [63:0]                    amo_resp_result_i,
  input  logic                           amo_valid_commit_i,
  input  logic                           no_st_pending_i,
  output logic                           result_valid_o,
  output logic [63:0]                    result_o,
  output logic [$clog2(DEPTH+1)-1:0]     usage_o,
  output logic                           timeout_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [3:0]        r_op   [DEPTH];
  logic [PLEN-1:0]   r_addr [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];
  logic [1:0]        r_size [DEPTH];
  logic              r_result_valid;
  logic [63:0]       r_result;
  logic              w_push, w_pop, w_wr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign ready_o             = (r_count != CW'(DEPTH));
  assign usage_o             = r_count;
  assign amo_req_req_o       = (r_state == S_REQ);
  assign amo_req_amo_op_o    = r_op[r_head];
  assign amo_req_size_o      = r_size[r_head];
  assign amo_req_operand_a_o = 64'(r_addr[r_head]);
  assign amo_req_operand_b_o = 64'(r_data[r_head]);
  assign result_valid_o      = r_result_valid;
  assign result_o            = r_result;

  assign w_push = valid_i & ready_o;
  assign w_pop  = (r_state == S_REQ) & amo_resp_ack_i;

  // Pointer/occupancy update: flush prunes to the non-speculative head, otherwise push/pop.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    if (flush_i) begin
      if (w_pop) begin
        w_head_nxt  = ptr_inc(r_head);
        w_tail_nxt  = ptr_inc(r_head);
        w_count_nxt = '0;
      end else if (((r_state == S_REQ) || amo_valid_commit_i) && (r_count != '0)) begin
        w_tail_nxt  = ptr_inc(r_head);
        w_count_nxt = CW'(1);
      end else begin
        w_tail_nxt  = r_head;
        w_count_nxt = '0;
      end
    end else begin
      if (w_push) begin
        w_wr_en    = 1'b1;
        w_tail_nxt = ptr_inc(r_tail);
      end else begin
        w_tail_nxt = r_tail;
      end
      if (w_pop) w_head_nxt = ptr_inc(r_head);
      else       w_head_nxt = r_head;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Issue FSM next state; once in REQ the request is held until ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && amo_valid_commit_i && no_st_pending_i) w_state_nxt = S_REQ;
        else                                                          w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (amo_resp_ack_i) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pointers, storage and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_result_valid <= 1'b0;
      r_result       <= 64'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_op[i]   <= 4'd0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_size[i] <= 2'd0;
      end
    end else if (clr_i) begin
      r_state        <= S_IDLE;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_result_valid <= 1'b0;
      r_result       <= 64'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_head         <= w_head_nxt;
      r_tail         <= w_tail_nxt;
      r_count        <= w_count_nxt;
      r_result_valid <= w_pop;
      if (w_pop) r_result <= amo_resp_result_i;
      if (w_wr_en) begin
        r_op[r_tail]   <= amo_op_i;
        r_addr[r_tail] <= paddr_i;
        r_data[r_tail] <= data_i;
        r_size[r_tail] <= data_size_i;
      end
    end
  end

`ifdef AMO_QUEUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;

  // Watchdog: counts REQ cycles without ack; the flag is sticky, the request is not withdrawn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (clr_i) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if ((r_state == S_REQ) && !amo_resp_ack_i) begin
      if (r_tmo_cnt != TW'(TIMEOUT_CYCLES)) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
